// File: rtl/bla_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock, trial subtract via 4-bit borrow-lookahead slices.
// Optional divide-by-zero fast path and flag output enabled by defining BLA_DIV_ZERO_EN.
module bla_divider #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
`ifdef BLA_DIV_ZERO_EN
   ,
   output logic             div_by_zero
`endif
);

   localparam int NS = WIDTH / 4;
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] r;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] dsr;
   logic [CW-1:0]    cnt;

   // The partial remainder always fits in WIDTH bits; the extra bit exists only in the shifted operand x.
   logic [WIDTH:0]   x, y, g, p;
   logic [WIDTH-1:0] bvec, trial;
   logic             bin, borrow;

   assign x = {r, q[WIDTH-1]};
   assign y = {1'b0, dsr};
   assign g = ~x & y;
   assign p = ~(x ^ y);

   // NOTE: every variable written here gets a default first, so no latch can be inferred;
   // blocking assignments are correct in combinational logic because bin is reused within the pass.
   always_comb begin
      bvec   = '0;
      bin    = 1'b0;
      borrow = 1'b0;
      for (int s = 0; s < NS; s++) begin
         bvec[4*s]   = bin;
         bvec[4*s+1] = g[4*s] | (p[4*s] & bin);
         bvec[4*s+2] = g[4*s+1] | (p[4*s+1] & g[4*s]) | (p[4*s+1] & p[4*s] & bin);
         bvec[4*s+3] = g[4*s+2] | (p[4*s+2] & g[4*s+1]) | (p[4*s+2] & p[4*s+1] & g[4*s])
                     | (p[4*s+2] & p[4*s+1] & p[4*s] & bin);
         bin         = g[4*s+3] | (p[4*s+3] & g[4*s+2]) | (p[4*s+3] & p[4*s+2] & g[4*s+1])
                     | (p[4*s+3] & p[4*s+2] & p[4*s+1] & g[4*s])
                     | (p[4*s+3] & p[4*s+2] & p[4*s+1] & p[4*s] & bin);
      end
      // Single-bit top stage; its difference bit is zero whenever there is no borrow.
      borrow = g[WIDTH] | (p[WIDTH] & bin);
      trial  = x[WIDTH-1:0] ^ y[WIDTH-1:0] ^ bvec;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: state_nxt = start ? RUN : IDLE;
         RUN:        if (cnt == '0) state_nxt = DONE;
         default:    state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);

`ifdef BLA_DIV_ZERO_EN
   logic dz;
   assign div_by_zero = done & dz;
`endif

   // RUN steps while cnt != 0; the extra cycle at cnt == 0 publishes the result as DONE is entered.
   always_ff @(posedge clk) begin
      if (rst) begin
         r         <= '0;
         q         <= '0;
         dsr       <= '0;
         cnt       <= '0;
         quotient  <= '0;
         remainder <= '0;
`ifdef BLA_DIV_ZERO_EN
         dz        <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  r   <= '0;
                  q   <= dividend;
                  dsr <= divisor;
                  cnt <= CW'(WIDTH);
`ifdef BLA_DIV_ZERO_EN
                  dz  <= (divisor == '0);
                  if (divisor == '0) begin
                     r   <= dividend;
                     q   <= '1;
                     cnt <= '0;
                  end
`endif
               end
            end
            RUN: begin
               if (cnt != '0) begin
                  r   <= borrow ? x[WIDTH-1:0] : trial;
                  q   <= {q[WIDTH-2:0], ~borrow};
                  cnt <= cnt - CW'(1);
               end else begin
                  quotient  <= q;
                  remainder <= r;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bla_divider.sv
// Scoreboard bench for bla_divider (WIDTH=8): stimulus pushes expected results, a negedge monitor pops on done.
// Follows BLA_DIV_ZERO_EN when defined for the divide-by-zero expectations.
module tb_bla_divider;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] dividend, divisor;
   logic         busy, done;
   logic [W-1:0] quotient, remainder;
`ifdef BLA_DIV_ZERO_EN
   logic         div_by_zero;
`endif

   bla_divider #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .dividend  (dividend),
      .divisor   (divisor),
      .busy      (busy),
      .done      (done),
      .quotient  (quotient),
      .remainder (remainder)
`ifdef BLA_DIV_ZERO_EN
      ,
      .div_by_zero (div_by_zero)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dz;
      int           due;
   } exp_t;

   exp_t         sb[$];
   int           cyc = 0;
   int           n_checks = 0;
   int           n_fail = 0;
   logic [W-1:0] hold_q = '0;
   logic [W-1:0] hold_r = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation, including its cycle.
   always @(negedge clk) begin
      if (!rst && done) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done: got done=1, expected no result (cycle %0d)", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("quotient", quotient, e.q);
            check("remainder", remainder, e.r);
            check("done_cycle", cyc, e.due);
`ifdef BLA_DIV_ZERO_EN
            check("div_by_zero", div_by_zero, e.dz);
`endif
            hold_q = e.q;
            hold_r = e.r;
         end
      end
   end

   task automatic do_start(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] eq, input logic [W-1:0] er);
      exp_t e;
      int   lat;
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      lat      = W + 1;
      e.q      = eq;
      e.r      = er;
      e.dz     = 1'b0;
`ifdef BLA_DIV_ZERO_EN
      if (b == '0) begin
         e.dz = 1'b1;
         lat  = 1;
      end
`endif
      e.due = cyc + 1 + lat;
      sb.push_back(e);
      @(posedge clk); #1;
      start    = 1'b0;
      dividend = W'($urandom);
      divisor  = W'($urandom);
   endtask

   // Waits (bounded) for the done cycle; optionally checks the previous result is held meanwhile.
   task automatic wait_done(input bit chk_hold, input logic [W-1:0] hq, input logic [W-1:0] hr);
      bit seen = 1'b0;
      for (int i = 0; i < 3 * W && !seen; i++) begin
         if (done) seen = 1'b1;
         else begin
            if (chk_hold) begin
               check("hold_quotient", quotient, hq);
               check("hold_remainder", remainder, hr);
            end
            @(posedge clk); #1;
         end
      end
      if (!seen) begin
         check("done_timeout", 0, 1);
         sb.delete();
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_quotient", quotient, 0);
      check("reset_remainder", remainder, 0);
`ifdef BLA_DIV_ZERO_EN
      check("reset_div_by_zero", div_by_zero, 0);
`endif
      rst = 1'b0;
      @(posedge clk); #1;

      // 100/7: busy for exactly W+1 cycles after the start edge, then done.
      do_start(8'd100, 8'd7, 8'd14, 8'd2);
      check("busy_after_start", busy, 1);
      for (int k = 1; k < W + 1; k++) begin
         @(posedge clk); #1;
         check("busy_run", busy, 1);
         check("no_early_done", done, 0);
      end
      @(posedge clk); #1;
      check("busy_falls", busy, 0);
      check("done_rises", done, 1);
      @(posedge clk); #1;
      check("done_one_cycle", done, 0);
      check("result_held_q", quotient, 8'd14);

      // Boundary vectors.
      do_start(8'd255, 8'd1, 8'd255, 8'd0);   wait_done(1'b0, '0, '0); @(posedge clk); #1;
      do_start(8'd5, 8'd9, 8'd0, 8'd5);       wait_done(1'b0, '0, '0); @(posedge clk); #1;
      do_start(8'd0, 8'd3, 8'd0, 8'd0);       wait_done(1'b0, '0, '0); @(posedge clk); #1;
      do_start(8'd255, 8'd255, 8'd1, 8'd0);   wait_done(1'b0, '0, '0); @(posedge clk); #1;
      do_start(8'd254, 8'd255, 8'd0, 8'd254); wait_done(1'b0, '0, '0); @(posedge clk); #1;
      do_start(8'd200, 8'd0, 8'd255, 8'd200); wait_done(1'b0, '0, '0); @(posedge clk); #1;

      // Strided sweep against the language's own / and %.
      for (int a = 0; a < 256; a += 17) begin
         for (int b = 1; b < 256; b += 23) begin
            do_start(W'(a), W'(b), W'(a / b), W'(a % b));
            wait_done(1'b0, '0, '0);
            @(posedge clk); #1;
         end
      end

      // start while busy is ignored; prior outputs stay put until done.
      do_start(8'd100, 8'd7, 8'd14, 8'd2);
      begin
         logic [W-1:0] hq, hr;
         hq = hold_q; hr = hold_r;
         repeat (2) @(posedge clk);
         #1;
         start = 1'b1; dividend = 8'd50; divisor = 8'd5;
         @(posedge clk); #1;
         start = 1'b0;
         wait_done(1'b1, hq, hr);
      end
      @(posedge clk); #1;

      // Reset mid-flight: outputs clear, no done, then a fresh division works.
      do_start(8'd100, 8'd7, 8'd14, 8'd2);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      sb.delete();
      @(posedge clk); #1;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_quotient", quotient, 0);
      check("abort_remainder", remainder, 0);
      rst = 1'b0;
      hold_q = '0; hold_r = '0;
      repeat (12) @(posedge clk);
      #1;
      check("abort_no_done", done, 0);
      do_start(8'd9, 8'd2, 8'd4, 8'd1);
      wait_done(1'b1, 8'd0, 8'd0);
      @(posedge clk); #1;

      // Back-to-back: start accepted in the done cycle, first result held until the second done.
      do_start(8'd100, 8'd7, 8'd14, 8'd2);
      wait_done(1'b0, '0, '0);
      do_start(8'd81, 8'd9, 8'd9, 8'd0);
      check("b2b_busy", busy, 1);
      wait_done(1'b1, 8'd14, 8'd2);
      @(posedge clk); #1;

      for (int i = 0; i < 4 * W && sb.size() != 0; i++) begin
         @(posedge clk); #1;
      end
      check("scoreboard_empty", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
